addsub_serial_16bit: RTL

Multi-cycle, nibble-serial 16-bit saturating adder/subtractor with a start/done handshake. It is the sequential counterpart of the single-cycle CLA_16bit. It gives the same arithmetic result, including saturation, by passing one 4-bit slice per cycle through a single 4-bit CLA. It sits in the execute stage as the low-area arithmetic path, for ops that can tolerate multi-cycle latency.

---
 rtl/addsub_serial_16bit_pkg.sv | 31 +++
 rtl/addsub_serial_16bit_cla.sv | 37 +++
 rtl/addsub_serial_16bit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/addsub_serial_16bit_pkg.sv
// Shared types and constants for the nibble-serial saturating adder/subtractor.
package addsub_pkg;

    localparam int WIDTH   = 16;
    localparam int NIB     = 4;
    localparam int NIB_CNT = WIDTH / NIB;

    localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Clamp a raw two's-complement sum toward the sign of operand A on overflow.
    function automatic logic [WIDTH-1:0] saturate(
        input logic [WIDTH-1:0] raw,
        input logic             a_msb,
        input logic             ovf
    );
        if (!ovf)
            return raw;
        else if (a_msb)
            return SAT_NEG;
        else
            return SAT_POS;
    endfunction

endpackage

// File: rtl/addsub_serial_16bit_cla.sv
// 4-bit carry-lookahead adder slice; the serial datapath reuses one instance per nibble.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Per-bit generate and propagate terms.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gp
            assign g[gi] = a[gi] & b[gi];
            assign p[gi] = a[gi] ^ b[gi];
        end
    endgenerate

    // Fully expanded lookahead carries so no carry ripples through the slice.
    always_comb begin
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    end

    assign s    = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/addsub_serial_16bit.sv
// Nibble-serial 16-bit saturating adder/subtractor with start/done handshake.
// One 4-bit CLA is time-multiplexed over the four nibbles, low nibble first.
module addsub_serial_16bit
    import addsub_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             ovfl
);

    state_t           state_reg,  state_next;
    logic [1:0]       cnt_reg,    cnt_next;
    logic             carry_reg,  carry_next;
    logic [WIDTH-1:0] a_reg,      a_next;
    logic [WIDTH-1:0] bop_reg,    bop_next;
    logic [WIDTH-1:0] raw_reg,    raw_next;
    logic [WIDTH-1:0] s_reg,      s_next;
    logic             ovfl_reg,   ovfl_next;

    logic [NIB-1:0]   a_slice   [NIB_CNT];
    logic [NIB-1:0]   bop_slice [NIB_CNT];
    logic [NIB-1:0]   slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] raw_full;
    logic             ovf_full;

    // Break the captured operands into nibbles for the slice multiplexer.
    genvar gi;
    generate
        for (gi = 0; gi < NIB_CNT; gi++) begin : g_slice
            assign a_slice[gi]   = a_reg[gi*NIB +: NIB];
            assign bop_slice[gi] = bop_reg[gi*NIB +: NIB];
        end
    endgenerate

    cla_4bit u_cla (
        .a    (a_slice[cnt_reg]),
        .b    (bop_slice[cnt_reg]),
        .cin  (carry_reg),
        .s    (slice_sum),
        .cout (slice_cout)
    );

    // Raw sum including the nibble being produced this cycle, so the final
    // slice and the saturation decision land on the same edge.
    always_comb begin
        raw_full = raw_reg;
        raw_full[{cnt_reg, 2'b00} +: NIB] = slice_sum;
        ovf_full = (a_reg[WIDTH-1] == bop_reg[WIDTH-1])
                && (raw_full[WIDTH-1] != a_reg[WIDTH-1]);
    end

    // Next-state and datapath update; DONE accepts a new start like IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        carry_next = carry_reg;
        a_next     = a_reg;
        bop_next   = bop_reg;
        raw_next   = raw_reg;
        s_next     = s_reg;
        ovfl_next  = ovfl_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = CALC;
                    a_next     = A;
                    bop_next   = sub ? ~B : B;
                    carry_next = sub;
                    cnt_next   = 2'd0;
                    raw_next   = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                raw_next   = raw_full;
                carry_next = slice_cout;
                cnt_next   = cnt_reg + 2'd1;
                if (cnt_reg == 2'(NIB_CNT - 1)) begin
                    state_next = DONE;
                    s_next     = saturate(raw_full, a_reg[WIDTH-1], ovf_full);
                    ovfl_next  = ovf_full;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            bop_reg   <= '0;
            raw_reg   <= '0;
            s_reg     <= '0;
            ovfl_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            carry_reg <= carry_next;
            a_reg     <= a_next;
            bop_reg   <= bop_next;
            raw_reg   <= raw_next;
            s_reg     <= s_next;
            ovfl_reg  <= ovfl_next;
        end
    end

    assign busy = (state_reg == CALC);
    assign done = (state_reg == DONE);
    assign S    = s_reg;
    assign ovfl = ovfl_reg;

endmodule
